// File: rtl/cd_llc_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cd_llc_slice
// Purpose  : LLC slice endpoint of the CD-mesh. Queues crossbar requests in a
//            FIFO, serves them in order against a local 16-bit word store and
//            returns one reply per request, keeping srcx/srcy for the return
//            route.
// Revision : 1.0 - initial release
// ============================================================================
module cd_llc_slice #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int LAT      = 3,
  parameter int SLICE_ID = 0,
  parameter int MEM_AW   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_si,
  output logic                     req_ri,
  input  logic [DATA_W-1:0]        req_di,
  output logic                     rep_so,
  input  logic                     rep_ro,
  output logic [DATA_W-1:0]        rep_do,
  output logic [$clog2(DEPTH):0]   occ,
  output logic [7:0]               err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int MEM_N = 1 << MEM_AW;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LAT - 1);
  localparam logic [1:0]       SLICE_ID_L = 2'(SLICE_ID);
  localparam logic [PTR_W:0]   OCC_FULL   = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    REPLY = 2'd2
  } state_t;

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [15:0]       mem_q [MEM_N];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] srv_q, srv_d;
  logic [DATA_W-1:0] rep_q, rep_d;
  logic [7:0]        err_q, err_d;

  logic              empty, full, push, pop, exec;
  logic [DATA_W-1:0] head;
  logic              srv_wr;
  logic [MEM_AW-1:0] srv_addr;
  logic [15:0]       srv_wdata, exec_data;
  logic              unused_bits;

  // Ready depends only on registered occupancy, never on req_si.
  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_FULL);
  assign req_ri  = !full;
  assign push    = req_si && !full;
  assign head    = fifo_mem[rd_ptr_q];

  // Fields of the request currently in service.
  assign srv_wr    = srv_q[56];
  assign srv_addr  = srv_q[16 +: MEM_AW];
  assign srv_wdata = srv_q[15:0];
  assign exec_data = srv_wr ? srv_wdata : mem_q[srv_addr];
  assign unused_bits = ^{srv_q[60:57], srv_q[31:16+MEM_AW]};

  assign rep_so  = (state_q == REPLY);
  assign rep_do  = rep_q;
  assign occ     = occ_q;
  assign err_cnt = err_q;

  // FIFO storage; contents are don't-care until pushed, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= req_di;
  end

  // Word store: cleared on reset, written when a write op executes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
    end else if (exec && srv_wr) begin
      mem_q[srv_addr] <= srv_wdata;
    end
  end

  // Service sequencer: load from FIFO, count down LAT cycles, hold reply.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    srv_d   = srv_q;
    rep_d   = rep_q;
    pop     = 1'b0;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          srv_d   = head;
          cnt_d   = CNT_LOAD;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (cnt_q == '0) begin
          exec    = 1'b1;
          rep_d   = {srv_q[63:61], 1'b1, 3'b000, srv_wr, srv_q[55:32],
                     16'h0000, exec_data};
          state_d = REPLY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      REPLY: begin
        // Reload straight into SERVE on the handshake edge to avoid a bubble.
        if (rep_ro) begin
          if (!empty) begin
            pop     = 1'b1;
            srv_d   = head;
            cnt_d   = CNT_LOAD;
            state_d = SERVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push/pop leaves occ.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      occ_d = occ_q + (PTR_W + 1)'(1);
    else if (pop && !push) occ_d = occ_q - (PTR_W + 1)'(1);
  end

  // Misroute counter, checked on the popped head, saturating at 255.
  always_comb begin
    err_d = err_q;
    if (pop && (head[53:52] != SLICE_ID_L) && (err_q != 8'hFF))
      err_d = err_q + 8'd1;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      srv_q    <= '0;
      rep_q    <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      srv_q    <= srv_d;
      rep_q    <= rep_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cd_llc_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cd_llc_slice
// Purpose  : Self-checking bench for cd_llc_slice (LAT=3 main instance plus a
//            LAT=1 instance for the back-to-back / wrap-around case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cd_llc_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_si, req_ri, rep_so, rep_ro;
  logic [63:0] req_di, rep_do;
  logic [2:0]  occ;
  logic [7:0]  err_cnt;

  logic        req_si1, req_ri1, rep_so1, rep_ro1;
  logic [63:0] req_di1, rep_do1;
  logic [2:0]  occ1;
  logic [7:0]  err_cnt1;

  cd_llc_slice #(.DATA_W(64), .DEPTH(4), .LAT(3), .SLICE_ID(0), .MEM_AW(4)) u_dut (
    .clk(clk), .reset(reset), .req_si(req_si), .req_ri(req_ri), .req_di(req_di),
    .rep_so(rep_so), .rep_ro(rep_ro), .rep_do(rep_do), .occ(occ), .err_cnt(err_cnt));

  cd_llc_slice #(.DATA_W(64), .DEPTH(4), .LAT(1), .SLICE_ID(0), .MEM_AW(4)) u_dut_l1 (
    .clk(clk), .reset(reset), .req_si(req_si1), .req_ri(req_ri1), .req_di(req_di1),
    .rep_so(rep_so1), .rep_ro(rep_ro1), .rep_do(rep_do1), .occ(occ1), .err_cnt(err_cnt1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mkpkt(input logic [2:0] vdd, input logic [3:0] hx,
                                        input logic [7:0] sx, input logic [7:0] sy,
                                        input logic wr, input logic [3:0] a,
                                        input logic [15:0] wd);
    return {vdd, 4'b0000, wr, hx, 4'h0, sx, sy, 12'h000, a, wd};
  endfunction

  // ---------------- reference model (main instance) ----------------
  // Requests are applied to a model store in acceptance order; since service
  // is strictly in order this yields each reply before the DUT produces it.
  logic [63:0] exp_q[$];
  bit          mis_q[$];
  logic [15:0] mmem [16];
  int          mis_done;
  bit          prev_stall;
  logic [63:0] prev_rep;

  initial begin
    logic [63:0] e;
    logic [15:0] d;
    bit          m;
    int          sz;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        mis_q.delete();
        foreach (mmem[i]) mmem[i] = 16'h0;
        mis_done   = 0;
        prev_stall = 0;
      end else begin
        sz = exp_q.size();
        chk("req_ri_vs_full", {63'b0, req_ri}, {63'b0, occ != 3'd4});
        checks++;
        if (!(occ == sz || (sz > 0 && int'(occ) == sz - 1))) begin
          errors++;
          $display("FAIL occ_track: got %0d expected %0d or %0d", occ, sz, sz - 1);
        end
        if (prev_stall) begin
          chk("stall_rep_so", {63'b0, rep_so}, 64'd1);
          chk("stall_rep_do", rep_do, prev_rep);
        end
        if (rep_so && rep_ro) begin
          if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_reply: got %h expected no reply", rep_do);
          end else begin
            e = exp_q.pop_front();
            m = mis_q.pop_front();
            if (m) mis_done++;
            chk("reply_pkt", rep_do, e);
            chk("reply_err_cnt", {56'b0, err_cnt}, (mis_done > 255) ? 64'd255 : 64'(mis_done));
          end
        end
        if (req_si && req_ri) begin
          if (req_di[56]) begin
            mmem[req_di[19:16]] = req_di[15:0];
            d = req_di[15:0];
          end else begin
            d = mmem[req_di[19:16]];
          end
          exp_q.push_back({req_di[63:61], 1'b1, 3'b000, req_di[56], req_di[55:32], 16'h0000, d});
          mis_q.push_back(req_di[53:52] != 2'd0);
        end
        prev_stall = rep_so && !rep_ro;
        prev_rep   = rep_do;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] p);
    int n = 0;
    req_si = 1'b1;
    req_di = p;
    while (!req_ri && n < 300) begin
      tick();
      n++;
    end
    if (!req_ri) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_ri=0 expected acceptance within 300 cycles");
    end
    tick();
    req_si = 1'b0;
  endtask

  task automatic wait_rep(output logic [63:0] d, output int n);
    n = 0;
    while (!rep_so && n < 300) begin
      tick();
      n++;
    end
    if (!rep_so) begin
      checks++;
      errors++;
      $display("FAIL reply_timeout: got rep_so=0 expected reply within 300 cycles");
    end
    d = rep_do;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] d;
    int n, last;
    reset = 1'b0; req_si = 1'b0; req_di = '0; rep_ro = 1'b1;
    req_si1 = 1'b0; req_di1 = '0; rep_ro1 = 1'b1;
    repeat (3) tick();
    chk("rst_rep_so", {63'b0, rep_so}, 64'd0);
    chk("rst_occ", {61'b0, occ}, 64'd0);
    chk("rst_err", {56'b0, err_cnt}, 64'd0);
    chk("rst_rep_do", rep_do, 64'd0);
    reset = 1'b1;
    tick();
    chk("rst_req_ri", {63'b0, req_ri}, 64'd1);

    // Write BEEF to addr 5, measure latency and reply fields.
    send(mkpkt(3'b101, 4'h0, 8'd2, 8'd1, 1'b1, 4'd5, 16'hBEEF));
    wait_rep(d, n);
    chk("latency", 64'(n), 64'd4);
    chk("wr_rsv", {59'b0, d[60:56]}, 64'h11);
    chk("wr_srcx", {56'b0, d[47:40]}, 64'd2);
    chk("wr_srcy", {56'b0, d[39:32]}, 64'd1);
    chk("wr_payload", {32'b0, d[31:0]}, 64'h0000BEEF);
    chk("wr_vcdxdy", {61'b0, d[63:61]}, 64'h5);
    tick();

    // Read back addr 5 and untouched addr 6.
    send(mkpkt(3'b000, 4'h0, 8'd2, 8'd1, 1'b0, 4'd5, 16'h0));
    wait_rep(d, n);
    chk("rd5_payload", {32'b0, d[31:0]}, 64'h0000BEEF);
    chk("rd5_rsv", {59'b0, d[60:56]}, 64'h10);
    tick();
    send(mkpkt(3'b000, 4'h0, 8'd3, 8'd0, 1'b0, 4'd6, 16'h0));
    wait_rep(d, n);
    chk("rd6_payload", {32'b0, d[31:0]}, 64'h0);
    tick();

    // Backpressure: 5 requests with the reply path stalled.
    rep_ro = 1'b0;
    for (int i = 0; i < 5; i++)
      send(mkpkt(3'b010, 4'h0, 8'(i), 8'd7, 1'b1, 4'(8 + i), 16'hC000 + 16'(i)));
    repeat (2) tick();
    chk("stall_occ", {61'b0, occ}, 64'd4);
    chk("stall_req_ri", {63'b0, req_ri}, 64'd0);
    repeat (5) tick();
    rep_ro = 1'b1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rep(d, n);
      chk("drain_payload", {32'b0, d[31:0]}, 64'hC000 + 64'(k));
      if (k > 0) chk("drain_spacing", 64'(cyc - last), 64'd4);
      last = cyc;
      tick();
    end

    // Single misroute, then 300 more to reach saturation.
    send(mkpkt(3'b000, 4'h2, 8'd1, 8'd1, 1'b0, 4'd0, 16'h0));
    wait_rep(d, n);
    chk("mis_rsv", {59'b0, d[60:56]}, 64'h10);
    tick();
    chk("mis_err1", {56'b0, err_cnt}, 64'd1);
    for (int i = 0; i < 300; i++)
      send(mkpkt(3'b000, 4'((i % 3) + 1), 8'd0, 8'd0, 1'b0, 4'(i % 16), 16'h0));
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    chk("mis_sat", {56'b0, err_cnt}, 64'd255);

    // Reset in the middle of service with three requests queued.
    send(mkpkt(3'b000, 4'h0, 8'd0, 8'd0, 1'b1, 4'd5, 16'h1234));
    wait_rep(d, n);
    tick();
    for (int i = 0; i < 4; i++)
      send(mkpkt(3'b000, 4'h1, 8'd0, 8'd0, 1'b0, 4'd5, 16'h0));
    chk("pre_rst_occ", {61'b0, occ}, 64'd3);
    chk("pre_rst_rep_so", {63'b0, rep_so}, 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_rep_so", {63'b0, rep_so}, 64'd0);
    chk("mid_rst_occ", {61'b0, occ}, 64'd0);
    chk("mid_rst_err", {56'b0, err_cnt}, 64'd0);
    chk("mid_rst_req_ri", {63'b0, req_ri}, 64'd1);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("post_rst_no_reply", {63'b0, rep_so}, 64'd0);
    send(mkpkt(3'b000, 4'h0, 8'd0, 8'd0, 1'b0, 4'd5, 16'h0));
    wait_rep(d, n);
    chk("post_rst_rd5", {32'b0, d[31:0]}, 64'h0);
    tick();

    // LAT=1 instance: pushes aligned with pops keep occ at 1 across wraps.
    begin
      int sent = 0;
      int got  = 0;
      int lst  = 0;
      for (int k = 0; k < 40; k++) begin
        if (sent < 10 && (k == 0 || (k % 2) == 1)) begin
          chk("l1_ready", {63'b0, req_ri1}, 64'd1);
          req_si1 = 1'b1;
          req_di1 = mkpkt(3'b000, 4'h0, 8'd4, 8'd4, 1'b1, 4'(sent % 16), 16'hA000 + 16'(sent));
          sent++;
        end else begin
          req_si1 = 1'b0;
        end
        if (k >= 1 && k <= 18) chk("l1_occ", {61'b0, occ1}, 64'd1);
        if (rep_so1) begin
          chk("l1_payload", {32'b0, rep_do1[31:0]}, 64'hA000 + 64'(got));
          if (got > 0) chk("l1_spacing", 64'(cyc - lst), 64'd2);
          lst = cyc;
          got++;
        end
        tick();
      end
      chk("l1_count", 64'(got), 64'd10);
      chk("l1_err", {56'b0, err_cnt1}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
